// File: rtl/seq_chk_pkg.sv
// Shared limits and helpers for the sequence implication checker.
package seq_chk_pkg;

   localparam int NSTEP_MAX    = 8;
   localparam int DLY_MAX      = 4;
   localparam int CONS_DLY_MAX = 3;
   localparam int CNT_W_MAX    = 32;

   // Increment value by one unless it already holds the all-ones pattern
   // of the given width; callers keep only the low 'width' bits.
   function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                           input int unsigned width);
      logic [63:0] all_ones;
      all_ones = (64'd1 << width) - 64'd1;
      return (value >= all_ones) ? all_ones : value + 64'd1;
   endfunction

endpackage

// File: rtl/seq_chk_sat_cnt.sv
// Saturating event counter: counts inc pulses, holds at all-ones.
module seq_chk_sat_cnt
   import seq_chk_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [63:0]      nxt_wide;
   logic [63-CNT_W:0] unused_hi;

   // Next value computed in a wide container; only the low bits are kept.
   always_comb begin
      nxt_wide = sat_inc({{(64-CNT_W){1'b0}}, cnt}, CNT_W);
   end

   assign unused_hi = nxt_wide[63:CNT_W];

   // Counter register, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= nxt_wide[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/seq_impl_checker.sv
// Overlapping-attempt checker for "a0 ##DLY a1 ... ##DLY aN-1 |-> ##CONS_DLY cons".
// Each in-flight attempt is a token travelling down a shift register; tokens
// are killed at every step boundary where that step's antecedent bit is low.
module seq_impl_checker
   import seq_chk_pkg::*;
#(
   parameter int NSTEP    = 2,
   parameter int DLY      = 1,
   parameter int CONS_DLY = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NSTEP-1:0] ante_i,
   input  logic             cons_i,
   output logic             match_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic             fail_sticky_o,
   output logic [CNT_W-1:0] match_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o
);

   localparam int TOK_LEN = (NSTEP - 1) * DLY;

   generate
      if (NSTEP < 1 || NSTEP > NSTEP_MAX || DLY < 1 || DLY > DLY_MAX ||
          CONS_DLY < 0 || CONS_DLY > CONS_DLY_MAX || CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_param
         $error("seq_impl_checker: parameter out of range");
      end
   endgenerate

   logic start;
   logic match_raw;
   logic check;

   assign start = en & ante_i[0];

   generate
      if (TOK_LEN == 0) begin : g_single
         // Single-step antecedent: the start itself is the match.
         assign match_raw = start;
      end else begin : g_chain
         logic [TOK_LEN-1:0] tok;
         logic [TOK_LEN:0]   nxt;

         // Token advance: position j holds attempts started j cycles ago;
         // at multiples of DLY the matching step bit must be high.
         always_comb begin
            nxt    = '0;
            nxt[0] = start;
            for (int j = 1; j <= TOK_LEN; j++) begin
               if (j % DLY == 0) begin
                  nxt[j] = tok[j-1] & ante_i[j / DLY];
               end else begin
                  nxt[j] = tok[j-1];
               end
            end
         end

         // Token shift register; reset discards every in-flight attempt.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               tok <= '0;
            end else begin
               tok <= nxt[TOK_LEN-1:0];
            end
         end

         assign match_raw = nxt[TOK_LEN];
      end
   endgenerate

   generate
      if (CONS_DLY == 0) begin : g_imm
         // Overlapping implication: consequent checked in the match cycle.
         assign check = match_raw;
      end else begin : g_pend
         logic [CONS_DLY-1:0] pend;

         // Pending-check pipeline; one slot per cycle so back-to-back
         // matches each get their own check.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pend <= '0;
            end else begin
               pend[0] <= match_raw;
               for (int i = 1; i < CONS_DLY; i++) begin
                  pend[i] <= pend[i-1];
               end
            end
         end

         assign check = pend[CONS_DLY-1];
      end
   endgenerate

   // Pulses are masked while reset is held so nothing leaks from live inputs.
   assign match_o = match_raw & ~rst;
   assign pass_o  = check & cons_i & ~rst;
   assign fail_o  = check & ~cons_i & ~rst;

   // Sticky failure flag, set the cycle after the first fail pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_sticky_o <= 1'b0;
      end else if (fail_o) begin
         fail_sticky_o <= 1'b1;
      end
   end

   seq_chk_sat_cnt #(.CNT_W(CNT_W)) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .inc (match_o),
      .cnt (match_cnt_o)
   );

   seq_chk_sat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
      .clk (clk),
      .rst (rst),
      .inc (fail_o),
      .cnt (fail_cnt_o)
   );

endmodule

// File: doc/seq_impl_checker.md
SEQ_IMPL_CHECKER -- requirements
Module: seq_impl_checker

Interface
REQ-001 Parameter NSTEP, default 2, number of antecedent steps (1..8).
REQ-002 Parameter DLY, default 1, cycle delay between consecutive antecedent steps, ##DLY (1..4).
REQ-003 Parameter CONS_DLY, default 0, cycles from antecedent match to consequent check (0 = |->, 1 = |=>, max 3).
REQ-004 Parameter CNT_W, default 16, width of the event counters.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  attempt enable; when low, no new attempt starts; in-flight attempts continue.
REQ-008 ante_i  input  NSTEP  bit k is the step-k antecedent expression.
REQ-009 cons_i  input  1  consequent expression.
REQ-010 match_o  output  1  one-cycle pulse when any attempt completes the antecedent.
REQ-011 pass_o  output  1  one-cycle pulse when a consequent check succeeds.
REQ-012 fail_o  output  1  one-cycle pulse when a consequent check fails.
REQ-013 fail_sticky_o  output  1  set on first fail; held until reset.
REQ-014 match_cnt_o  output  CNT_W  saturating count of matches.
REQ-015 fail_cnt_o  output  CNT_W  saturating count of failures.

Function
REQ-016 Each cycle, with en=1 and ante_i[0]=1, the block starts a new attempt; attempts overlap, one per cycle, with no limit.
REQ-017 An attempt at step k<NSTEP-1 advances to step k+1 exactly DLY cycles later only if ante_i[k+1]=1 in that cycle; otherwise it is dropped silently (vacuous, no pass and no fail).
REQ-018 An attempt that reaches step NSTEP-1 is a match; match_o pulses in that same cycle (combinational from the tracking state and ante_i), so latency from the start cycle is (NSTEP-1)*DLY.
REQ-019 Tracking shall be a token shift register of length (NSTEP-1)*DLY, gated by ante_i at each step boundary.
REQ-020 The consequent check for a match occurs CONS_DLY cycles after the match; pass_o=cons_i and fail_o=!cons_i in the check cycle.
REQ-021 For CONS_DLY=0, pass_o/fail_o assert in the match cycle; for CONS_DLY>0, a CONS_DLY-deep pending shift register carries matches.
REQ-022 Two matches in consecutive cycles each produce their own check; at most one check is pending per cycle.
REQ-023 With NSTEP=1, a match is ante_i[0]&en in the same cycle; DLY is ignored.
REQ-024 Counters increment by 1 per match or fail and saturate at all-ones with no wrap.
REQ-025 The rise of fail_sticky_o lags the first fail_o pulse by one registered cycle.

Reset
REQ-026 While rst=1: token and pending registers are 0, counters are 0, and fail_sticky_o is 0; match_o, pass_o, and fail_o are forced to 0.
REQ-027 Reset mid-attempt discards all in-flight attempts and pending checks; no pulse derives from pre-reset state.
REQ-028 The first attempt may start in the first rising edge after rst deasserts.

Structure
REQ-029 Shared package seq_chk_pkg holds the parameter limits NSTEP_MAX=8, DLY_MAX=4, and CONS_DLY_MAX=3, and the saturating-increment function.
REQ-030 One sub-module, seq_chk_sat_cnt (CNT_W saturating counter with inc input), is instantiated twice.
REQ-031 Out-of-range parameters are a static elaboration error.

Verification
REQ-032 Defaults; ante_i=01 at cyc 5, 10 at cyc 6, cons_i=1 -> match_o and pass_o pulse at cyc 6; match_cnt=1, fail_cnt=0.
REQ-033 Defaults; same antecedent, cons_i=0 at cyc 6 -> fail_o at cyc 6, fail_sticky_o=1 from cyc 7, fail_cnt=1.
REQ-034 NSTEP=3, DLY=2, CONS_DLY=1; bit0 at cyc 2, bit1 at cyc 4, bit2 at cyc 6, cons_i=0 at cyc 7 -> match at cyc 6, fail at cyc 7.
REQ-035 Defaults; ante_i=11 held for cycles 10..14, cons_i=1 -> match pulses cycles 11..14 with no gaps; match_cnt=4.
REQ-036 Defaults; bit0 at cyc 5, bit1 low at cyc 6 -> no match, pass, or fail; counters unchanged (vacuous).
REQ-037 CNT_W=2; five fails -> fail_cnt saturates at 3. Also: rst pulse at cyc 6 between steps -> no match at cyc 6, and all outputs are 0.
